bp_btb: RTL and testbench

Parametrised branch target buffer with saturating-counter direction prediction for the fetch stage of the 5-stage pipeline. It replaces the fixed `pcpred = PC + INSTSIZE` policy with a tagged, direct-mapped table. The fetch stage queries the table every cycle. The execute stage trains it with resolved branch and JAL outcomes. A reset- or software-triggered walker clears the table one entry per cycle.

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_sat_counter.sv | 10 +
 rtl/bp_btb.sv | 107 ++++++++++
 tb/tb_bp_btb.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared entry layout, FSM states and counter constants for the branch target buffer.
package bp_pkg;
    localparam int BP_DBITS     = 32;
    localparam int BP_INDEXBITS = 6;
    localparam int BP_TAGBITS   = 8;
    localparam int BP_CTRBITS   = 2;

    typedef struct packed {
        logic                  valid;
        logic [BP_TAGBITS-1:0] tag;
        logic [BP_DBITS-1:0]   target;
        logic [BP_CTRBITS-1:0] ctr;
    } bp_entry_t;

    typedef enum logic {IDLE, FLUSH} bp_state_t;

    localparam logic [BP_CTRBITS-1:0] BP_WEAK_TAKEN = BP_CTRBITS'(1) << (BP_CTRBITS - 1);
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: saturating up/down step of a W-bit direction counter.
module bp_sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] ctr,
    input  logic         inc,
    output logic [W-1:0] ctr_next
);
    always_comb ctr_next = inc ? ((&ctr) ? ctr : ctr + W'(1)) : ((|ctr) ? ctr - W'(1) : ctr);
endmodule

// File: rtl/bp_btb.sv
// bp_btb: direct-mapped tagged BTB with saturating-counter direction and a one-entry-per-cycle clear walker.
// Optional performance counters are built when BP_STATS_EN is defined; entry widths come from bp_pkg.
module bp_btb import bp_pkg::*; #(
    parameter int DBITS     = BP_DBITS,
    parameter int INSTSIZE  = 4,
    parameter int INDEXBITS = BP_INDEXBITS,
    parameter int TAGBITS   = BP_TAGBITS,
    parameter int CTRBITS   = BP_CTRBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] pc_fe,
    output logic [DBITS-1:0] pcpred_fe,
    output logic             predtaken_fe,
    input  logic             upd_valid_ex,
    input  logic [DBITS-1:0] upd_pc_ex,
    input  logic             upd_taken_ex,
    input  logic [DBITS-1:0] upd_target_ex,
    input  logic             upd_mispred_ex,
    input  logic             flush_req,
    output logic             busy,
    output logic [31:0]      stat_lookups,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_mispreds
);
    localparam int NENT = 1 << INDEXBITS;

    bp_state_t state_q, state_d;
    logic [INDEXBITS-1:0] walk_q, walk_d, idx_fe, idx_ex, wr_idx;
    logic [TAGBITS-1:0] tag_fe, tag_ex;
    logic [CTRBITS-1:0] ctr_upd;
    logic hit_fe, hit_ex, wr_en;
    bp_entry_t rd_fe, rd_ex, wr_data;
    bp_entry_t tbl [NENT];

    assign busy   = state_q == FLUSH;
    assign idx_fe = pc_fe[INDEXBITS+1:2];
    assign tag_fe = pc_fe[INDEXBITS+TAGBITS+1:INDEXBITS+2];
    assign idx_ex = upd_pc_ex[INDEXBITS+1:2];
    assign tag_ex = upd_pc_ex[INDEXBITS+TAGBITS+1:INDEXBITS+2];
    assign rd_fe  = tbl[idx_fe];
    assign rd_ex  = tbl[idx_ex];
    assign hit_fe = rd_fe.valid && rd_fe.tag == tag_fe;
    assign hit_ex = rd_ex.valid && rd_ex.tag == tag_ex;

    assign predtaken_fe = hit_fe && rd_fe.ctr[CTRBITS-1] && !busy;
    assign pcpred_fe    = predtaken_fe ? rd_fe.target : pc_fe + DBITS'(INSTSIZE);

    bp_sat_counter #(.W(CTRBITS)) u_ctr (
        .ctr      (rd_ex.ctr),
        .inc      (upd_taken_ex),
        .ctr_next (ctr_upd)
    );

    // Single write port shared by the clear walker and training, which never overlap.
    always_comb begin
        wr_en   = busy || (upd_valid_ex && (hit_ex || upd_taken_ex));
        wr_idx  = busy ? walk_q : idx_ex;
        wr_data = busy ? bp_entry_t'('0)
                : hit_ex ? {1'b1, tag_ex, upd_taken_ex ? upd_target_ex : rd_ex.target, ctr_upd}
                : {1'b1, tag_ex, upd_target_ex, BP_WEAK_TAKEN};
    end

    always_ff @(posedge clk)
        if (wr_en) tbl[wr_idx] <= wr_data;

    always_comb begin
        state_d = flush_req ? FLUSH : (busy && &walk_q) ? IDLE : state_q;
        walk_d  = (flush_req || !busy) ? '0 : walk_q + INDEXBITS'(1);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= FLUSH;
            walk_q  <= '0;
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
        end

`ifdef BP_STATS_EN
    logic [31:0] lookups_q, hits_q, mispreds_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            lookups_q  <= '0;
            hits_q     <= '0;
            mispreds_q <= '0;
        end else begin
            lookups_q  <= lookups_q + 32'(!busy);
            hits_q     <= hits_q + 32'(hit_fe && !busy);
            mispreds_q <= mispreds_q + 32'(upd_valid_ex && upd_mispred_ex);
        end

    assign stat_lookups  = lookups_q;
    assign stat_hits     = hits_q;
    assign stat_mispreds = mispreds_q;
`else
    assign stat_lookups  = '0;
    assign stat_hits     = '0;
    assign stat_mispreds = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{pc_fe[1:0], pc_fe[DBITS-1:INDEXBITS+TAGBITS+2],
                           upd_pc_ex[1:0], upd_pc_ex[DBITS-1:INDEXBITS+TAGBITS+2], upd_mispred_ex};
endmodule

// File: tb/tb_bp_btb.sv
// tb_bp_btb: randomized and directed scoreboard bench for bp_btb against a table-level reference model.
module tb_bp_btb;
    logic        clk = 1'b1;
    logic        reset;
    logic [31:0] pc_fe, pcpred_fe, upd_pc_ex, upd_target_ex;
    logic        predtaken_fe, upd_valid_ex, upd_taken_ex, upd_mispred_ex, flush_req, busy;
    logic [31:0] stat_lookups, stat_hits, stat_mispreds;

    always #5 clk = ~clk;

    bp_btb dut (
        .clk(clk), .reset(reset), .pc_fe(pc_fe), .pcpred_fe(pcpred_fe), .predtaken_fe(predtaken_fe),
        .upd_valid_ex(upd_valid_ex), .upd_pc_ex(upd_pc_ex), .upd_taken_ex(upd_taken_ex),
        .upd_target_ex(upd_target_ex), .upd_mispred_ex(upd_mispred_ex), .flush_req(flush_req),
        .busy(busy), .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispreds(stat_mispreds)
    );

    typedef struct {
        logic [31:0] pcpred;
        logic        pt;
        logic        busy;
        logic [31:0] sl, sh, sm;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    bit          mv[64];
    int          mtag[64];
    logic [31:0] mtgt[64];
    int          mctr[64];
    int          busy_left;
    logic [31:0] cl, ch, cm;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    exp_t e;
    always @(negedge clk)
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pcpred_fe", pcpred_fe, e.pcpred);
            chk("predtaken_fe", 32'(predtaken_fe), 32'(e.pt));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("stat_lookups", stat_lookups, e.sl);
            chk("stat_hits", stat_hits, e.sh);
            chk("stat_mispreds", stat_mispreds, e.sm);
        end

    task automatic step(input bit r, input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                        input bit ut, input logic [31:0] utgt, input bit um, input bit fl);
        exp_t x;
        int   i, t, ui, utag;
        bit   mb, hit;
        reset = r; pc_fe = pc; upd_valid_ex = uv; upd_pc_ex = upc;
        upd_taken_ex = ut; upd_target_ex = utgt; upd_mispred_ex = um; flush_req = fl;
        if (r) begin
            busy_left = 64; cl = 0; ch = 0; cm = 0;
            foreach (mv[k]) mv[k] = 0;
        end
        i   = int'((pc >> 2) % 64);
        t   = int'((pc >> 8) % 256);
        mb  = busy_left > 0;
        hit = !mb && mv[i] && mtag[i] == t;
        x.pt     = hit && mctr[i] >= 2;
        x.pcpred = x.pt ? mtgt[i] : pc + 32'd4;
        x.busy   = mb;
`ifdef BP_STATS_EN
        x.sl = cl; x.sh = ch; x.sm = cm;
`else
        x.sl = 0; x.sh = 0; x.sm = 0;
`endif
        q.push_back(x);
        @(posedge clk);
        if (!r) begin
            cl += 32'(!mb);
            ch += 32'(hit);
            cm += 32'(uv && um);
            ui   = int'((upc >> 2) % 64);
            utag = int'((upc >> 8) % 256);
            if (uv && !mb) begin
                if (mv[ui] && mtag[ui] == utag) begin
                    mctr[ui] = ut ? (mctr[ui] == 3 ? 3 : mctr[ui] + 1) : (mctr[ui] == 0 ? 0 : mctr[ui] - 1);
                    if (ut) mtgt[ui] = utgt;
                end else if (ut) begin
                    mv[ui] = 1; mtag[ui] = utag; mtgt[ui] = utgt; mctr[ui] = 2;
                end
            end
            if (fl) begin
                busy_left = 64;
                foreach (mv[k]) mv[k] = 0;
            end else if (busy_left > 0) busy_left--;
        end
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        step(0, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input bit um);
        step(0, pc, 1, upc, ut, utgt, um, 0);
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
        if ($urandom_range(0, 15) == 0) p = $urandom & 32'hFFFF_FFFC;
        return p;
    endfunction

    initial begin
        reset = 0; pc_fe = 0; upd_valid_ex = 0; upd_pc_ex = 0; upd_taken_ex = 0;
        upd_target_ex = 0; upd_mispred_ex = 0; flush_req = 0;
        busy_left = 64; cl = 0; ch = 0; cm = 0;
        #1;
        repeat (3) step(1, 32'h100, 0, 0, 0, 0, 0, 0);
        repeat (66) look(32'h100);
        upd(32'h100, 32'h100, 1, 32'h200, 1);
        look(32'h100);
        upd(32'h100, 32'h100, 0, 0, 1);
        look(32'h100);
        upd(32'h100, 32'h100, 1, 32'h200, 0);
        upd(32'h100, 32'h100, 1, 32'h200, 0);
        upd(32'h100, 32'h100, 0, 0, 0);
        look(32'h100);
        look(32'h4100);
        upd(32'h4100, 32'h4100, 1, 32'h300, 1);
        look(32'h100);
        look(32'h4100);
        look(32'hFFFF_FFFC);
        upd(32'h180, 32'h180, 1, 32'h400, 0);
        look(32'h180);
        step(0, 32'h180, 1, 32'h184, 1, 32'h500, 0, 1);
        repeat (66) step(0, 32'h4100, 1, rpc(), 1, $urandom, $urandom_range(0, 1), 0);
        look(32'h180);
        look(32'h4100);
        look(32'h184);
        for (int n = 0; n < 900; n++) begin
            if (n == 300 || n == 310) step(1, rpc(), 0, 0, 0, 0, 0, 0);
            else step(0, rpc(), $urandom_range(0, 1), rpc(), $urandom_range(0, 2) != 0,
                      $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1),
                      n == 250 || n == 320 || $urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
